// File: rtl/label_rd_fifo.sv
// Level-tagged read-side FIFO: entries above the reader clearance are masked to zero, never dropped.
// Optional LABEL_FIFO_SCRUB_EN zeroes storage on pop and on reset.
module label_rd_fifo #(
  parameter int DW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [DW-1:0] wr_data_i,
  input  logic          wr_lvl_i,
  input  logic          rd_lvl_i,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_masked_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] lvl_q, lvl_d;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop, head_lvl;

  assign wr_ready_o = (count_q != FULL);
  assign rd_valid_o = (count_q != '0);
  assign push       = wr_valid_i & wr_ready_o;
  assign pop        = rd_valid_o & rd_ready_i;
  assign count_o    = count_q;

  // Control never looks at payload; only rd_data carries labeled content.
  assign head_lvl    = lvl_q[rptr_q];
  assign rd_masked_o = rd_valid_o & head_lvl & ~rd_lvl_i;
  assign rd_data_o   = (rd_valid_o && !rd_masked_o) ? mem_q[rptr_q] : '0;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    lvl_d   = lvl_q;
`ifdef LABEL_FIFO_SCRUB_EN
    if (pop) lvl_d[rptr_q] = 1'b0;
`endif
    if (push) begin
      lvl_d[wptr_q] = wr_lvl_i;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      lvl_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      lvl_q   <= lvl_d;
    end
  end

`ifdef LABEL_FIFO_SCRUB_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // Push and pop never target the same slot: push needs not-full, pop needs not-empty.
      if (pop)  mem_q[rptr_q] <= '0;
      if (push) mem_q[wptr_q] <= wr_data_i;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) mem_q[wptr_q] <= wr_data_i;
  end
`endif

endmodule

// File: tb/tb_label_rd_fifo.sv
// Self-checking bench for label_rd_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_label_rd_fifo;

  localparam int DW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid, wr_ready, wr_lvl, rd_lvl, rd_valid, rd_ready, rd_masked;
  logic [DW-1:0] wr_data, rd_data;
  logic [2:0]    count;

  int checks   = 0;
  int failures = 0;

  logic [DW:0] q[$];  // {lvl, data}

  always #5 clk = ~clk;

  label_rd_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(reset),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data), .wr_lvl_i(wr_lvl),
    .rd_lvl_i(rd_lvl), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .rd_data_o(rd_data), .rd_masked_o(rd_masked), .count_o(count)
  );

  // Expected {wr_ready, rd_valid, rd_data, rd_masked, count} from the model queue.
  function automatic logic [9:0] exp_vec();
    logic          v, m, h;
    logic [DW-1:0] d;
    v = (q.size() != 0);
    h = v ? q[0][DW] : 1'b0;
    m = v && h && !rd_lvl;
    d = (v && !m) ? q[0][DW-1:0] : '0;
    return {(q.size() != DEPTH), v, d, m, 3'(q.size())};
  endfunction

  task automatic tick();
    bit p, o;
    p = wr_valid && (q.size() != DEPTH);
    o = rd_ready && (q.size() != 0);
    @(posedge clk);
    if (o) void'(q.pop_front());
    if (p) q.push_back({wr_lvl, wr_data});
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; wr_valid = 0; rd_ready = 0; wr_data = '0; wr_lvl = 0; rd_lvl = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
  endtask

  task automatic push_one(input logic l, input logic [DW-1:0] d);
    wr_valid = 1; wr_lvl = l; wr_data = d; rd_ready = 0;
    tick();
    wr_valid = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({wr_ready, rd_valid, rd_data, rd_masked, count} !== 10'b1_0_0000_0_000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b", {wr_ready, rd_valid, rd_data, rd_masked, count}, 10'b1_0_0000_0_000);
    end
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 1; i <= 4; i++) push_one(1'b0, 4'(i));
    checks++;
    if (count !== 3'd4 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_flags count=%0d wr_ready=%b want count=4 wr_ready=0", count, wr_ready);
    end
    push_one(1'b0, 4'hF);
    checks++;
    if (count !== 3'd4) begin
      failures++;
      $display("FAIL fifth_push_ignored count=%0d want 4", count);
    end
    rd_lvl = 0; rd_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 4'(i)) begin
        failures++;
        $display("FAIL drain_order idx=%0d valid=%b data=%0d want data=%0d", i, rd_valid, rd_data, i);
      end
      tick();
    end
    rd_ready = 0;
    checks++;
    if (rd_valid !== 1'b0 || count !== 3'd0) begin
      failures++;
      $display("FAIL drained_empty valid=%b count=%0d want 0 0", rd_valid, count);
    end
  endtask

  task automatic test_masking(input logic lvl_sel);
    logic [DW-1:0] want_d [3];
    logic          want_m [3];
    apply_reset();
    push_one(1'b0, 4'd5);
    push_one(1'b1, 4'd9);
    push_one(1'b0, 4'd7);
    want_d[0] = 4'd5; want_d[1] = lvl_sel ? 4'd9 : 4'd0; want_d[2] = 4'd7;
    want_m[0] = 1'b0; want_m[1] = !lvl_sel;             want_m[2] = 1'b0;
    rd_lvl = lvl_sel; rd_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== want_d[i] || rd_masked !== want_m[i]) begin
        failures++;
        $display("FAIL mask_drain lvl=%b idx=%0d valid=%b data=%0d masked=%b want 1 %0d %b",
                 lvl_sel, i, rd_valid, rd_data, rd_masked, want_d[i], want_m[i]);
      end
      tick();
    end
    rd_ready = 0;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 4'd0 || rd_masked !== 1'b0) begin
      failures++;
      $display("FAIL mask_empty valid=%b data=%0d masked=%b want 0 0 0", rd_valid, rd_data, rd_masked);
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int i = 0; i < 4; i++) push_one(1'b0, 4'(i + 10));
    wr_valid = 1; wr_lvl = 0; wr_data = 4'd3; rd_ready = 1; rd_lvl = 0;
    tick();
    checks++;
    if (count !== 3'd3 || wr_ready !== 1'b1 || rd_data !== 4'd11) begin
      failures++;
      $display("FAIL full_push_pop count=%0d wr_ready=%b head=%0d want 3 1 11", count, wr_ready, rd_data);
    end
    rd_ready = 0;
    tick();
    wr_valid = 0;
    checks++;
    if (count !== 3'd4) begin
      failures++;
      $display("FAIL push_after_full count=%0d want 4", count);
    end
    for (int i = 0; i < 10; i++) begin
      wr_valid = (i % 3) != 2; rd_ready = (i % 2) == 0 || i == 9;
      wr_lvl = 1'($urandom_range(0, 1)); rd_lvl = 1'($urandom_range(0, 1));
      wr_data = 4'($urandom_range(0, 15));
      checks++;
      if ({wr_ready, rd_valid, rd_data, rd_masked, count} !== exp_vec()) begin
        failures++;
        $display("FAIL wrap_mixed op=%0d got=%b want=%b", i, {wr_ready, rd_valid, rd_data, rd_masked, count}, exp_vec());
      end
      tick();
    end
    wr_valid = 0; rd_ready = 0;
  endtask

  task automatic test_rd_lvl_toggle();
    apply_reset();
    push_one(1'b1, 4'd9);
    rd_lvl = 1; #1;
    checks++;
    if (rd_data !== 4'd9 || rd_masked !== 1'b0) begin
      failures++;
      $display("FAIL toggle_high data=%0d masked=%b want 9 0", rd_data, rd_masked);
    end
    rd_lvl = 0; #1;
    checks++;
    if (rd_data !== 4'd0 || rd_masked !== 1'b1 || count !== 3'd1) begin
      failures++;
      $display("FAIL toggle_low data=%0d masked=%b count=%0d want 0 1 1", rd_data, rd_masked, count);
    end
    rd_lvl = 1; #1;
    checks++;
    if (rd_data !== 4'd9) begin
      failures++;
      $display("FAIL toggle_restore data=%0d want 9", rd_data);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    push_one(1'b1, 4'd6);
    push_one(1'b0, 4'd2);
    rd_lvl = 1; #2;
    reset = 1'b1; #1;
    checks++;
    if ({wr_ready, rd_valid, rd_data, rd_masked, count} !== 10'b1_0_0000_0_000) begin
      failures++;
      $display("FAIL async_reset got=%b want=%b", {wr_ready, rd_valid, rd_data, rd_masked, count}, 10'b1_0_0000_0_000);
    end
`ifdef LABEL_FIFO_SCRUB_EN
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (dut.mem_q[i] !== 4'd0) begin
        failures++;
        $display("FAIL scrub_mem idx=%0d got=%0d want 0", i, dut.mem_q[i]);
      end
    end
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    push_one(1'b0, 4'd8);
    checks++;
    if (count !== 3'd1 || rd_data !== 4'd8) begin
      failures++;
      $display("FAIL post_reset_push count=%0d data=%0d want 1 8", count, rd_data);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      wr_valid = ($urandom_range(0, 99) < 60);
      rd_ready = ($urandom_range(0, 99) < 50);
      wr_lvl   = 1'($urandom_range(0, 1));
      rd_lvl   = 1'($urandom_range(0, 1));
      wr_data  = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if ({wr_ready, rd_valid, rd_data, rd_masked, count} !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b want=%b", i, {wr_ready, rd_valid, rd_data, rd_masked, count}, exp_vec());
      end
      tick();
    end
    wr_valid = 0; rd_ready = 0;
  endtask

  initial begin
    reset = 1'b1; wr_valid = 0; rd_ready = 0; wr_data = '0; wr_lvl = 0; rd_lvl = 0;
    test_reset();
    test_fill_drain();
    test_masking(1'b0);
    test_masking(1'b1);
    test_full_push_pop();
    test_rd_lvl_toggle();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
